// File: rtl/ems_sdram_bridge.sv
// Wishbone (16-bit) to SDRAM single-word request bridge with EMS address
// translation stage and a bounded wait so a lost controller response cannot
// stall the CPU.
module ems_sdram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] OPEN_BUS       = 16'hFFFF
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  // CPU side
  input  logic [19:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  // EMS translator
  output logic [19:1] xlat_adr_o,
  input  logic [31:0] xlat_adr_i,
  // SDRAM controller
  output logic        sdram_req_o,
  output logic        sdram_we_o,
  output logic [31:0] sdram_adr_o,
  output logic [31:0] sdram_dat_o,
  output logic [3:0]  sdram_be_o,
  input  logic        sdram_gnt_i,
  input  logic        sdram_rvalid_i,
  input  logic [31:0] sdram_dat_i,
  // status
  output logic        timeout_o
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    XLAT   = 3'd1,
    REQ    = 3'd2,
    RDWAIT = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       dat_q;
  logic [1:0]        sel_q;
  logic              we_q;

  logic              accept_c;
  logic              issue_c;
  logic              granted_c;
  logic              rdata_c;
  logic              abort_c;
  logic              tmo_c;
  logic              to_ack_c;

  // Upper half of each SDRAM slot carries no CPU data.
  logic              unused_dat_hi;
  assign unused_dat_hi = ^sdram_dat_i[31:16];

  // State register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and per-cycle action strobes; gnt/rvalid beat timeout.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    issue_c   = 1'b0;
    granted_c = 1'b0;
    rdata_c   = 1'b0;
    abort_c   = 1'b0;
    tmo_c     = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
          accept_c = 1'b1;
          state_d  = XLAT;
        end
      end
      XLAT: begin
        issue_c = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        if (sdram_gnt_i) begin
          granted_c = 1'b1;
          state_d   = we_q ? ACK : RDWAIT;
        end else if (tmo_c) begin
          abort_c = 1'b1;
          state_d = ACK;
        end
      end
      RDWAIT: begin
        if (sdram_rvalid_i) begin
          rdata_c = 1'b1;
          state_d = ACK;
        end else if (tmo_c) begin
          abort_c = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    to_ack_c = (granted_c && we_q) || rdata_c || abort_c;
  end

  // Holding registers, SDRAM request outputs, wait counter and CPU response.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      xlat_adr_o  <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      sdram_req_o <= 1'b0;
      sdram_we_o  <= 1'b0;
      sdram_adr_o <= '0;
      sdram_dat_o <= '0;
      sdram_be_o  <= '0;
      cnt_q       <= '0;
      wb_dat_o    <= '0;
      wb_ack_o    <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      if (accept_c) begin
        xlat_adr_o <= wb_adr_i;
        dat_q      <= wb_dat_i;
        sel_q      <= wb_sel_i;
        we_q       <= wb_we_i;
      end

      if (issue_c) begin
        sdram_adr_o <= xlat_adr_i;
        sdram_we_o  <= we_q;
        sdram_dat_o <= {16'h0000, dat_q};
        sdram_be_o  <= {2'b00, sel_q};
        sdram_req_o <= 1'b1;
      end else if (granted_c || abort_c) begin
        sdram_req_o <= 1'b0;
      end

      // Cleared on entry to REQ and RDWAIT, counts while waiting there.
      if (issue_c || (granted_c && !we_q)) begin
        cnt_q <= '0;
      end else if (state_q == REQ || state_q == RDWAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (rdata_c) begin
        wb_dat_o <= sdram_dat_i[15:0];
      end else if (abort_c && !we_q) begin
        wb_dat_o <= OPEN_BUS;
      end

      if (abort_c) timeout_o <= 1'b1;

      // Ack only if the master is still waiting for this cycle.
      wb_ack_o <= to_ack_c && wb_cyc_i && wb_stb_i;
    end
  end

endmodule
